// File: rtl/ring_monitor.sv
// Checks a one-hot ring counter for validity and rotation order, locks after a
// run of good steps, then reports phase, revolutions and corruption events.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_SEARCH | waiting for any one-hot sample to start tracking
// S_TRACK  | counting consecutive good advancing steps towards lock
// S_LOCKED | ring verified; bad samples raise error events
module ring_monitor #(
    parameter int W      = 4,
    parameter int REV_W  = 8,
    parameter int LOCK_N = 2,
    localparam int PH_W  = $clog2(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     ring,
    input  logic             step,
    input  logic             clr,
    output logic             locked,
    output logic [PH_W-1:0]  phase,
    output logic [REV_W-1:0] rev_cnt,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [7:0]       err_cnt
);

    localparam int CNT_W = $clog2(LOCK_N + 1);

    typedef enum logic [1:0] {
        S_SEARCH,
        S_TRACK,
        S_LOCKED
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       prev_q, prev_d;
    logic               locked_q, locked_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [REV_W-1:0]   rev_cnt_q, rev_cnt_d;
    logic               err_pulse_q, err_pulse_d;
    logic               err_sticky_q, err_sticky_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    logic               onehot;
    logic [W-1:0]       rot_prev;
    logic               good_adv;
    logic               good_hold;
    logic [PH_W-1:0]    hot_idx;
    logic               err_ev;
    logic               rev_ev;
    logic [7:0]         err_base;

    always_comb begin
        onehot    = $onehot(ring);
        rot_prev  = {prev_q[0], prev_q[W-1:1]};
        good_adv  = step & onehot & (ring == rot_prev);
        good_hold = ~step & onehot & (ring == prev_q);
        hot_idx   = '0;
        for (int i = 0; i < W; i++) begin
            if (ring[i]) hot_idx = PH_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_ev  = 1'b0;
        rev_ev  = 1'b0;
        case (state_q)
            S_SEARCH: begin
                if (onehot) begin
                    state_d = S_TRACK;
                    cnt_d   = '0;
                end
            end
            S_TRACK: begin
                if (good_adv) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(LOCK_N - 1)) state_d = S_LOCKED;
                end else if (!good_hold) begin
                    state_d = S_SEARCH;
                end
            end
            S_LOCKED: begin
                if (good_adv || good_hold) begin
                    // wrap from bit 0 back to the top bit closes a revolution
                    rev_ev = good_adv & ring[W-1];
                end else begin
                    state_d = S_SEARCH;
                    err_ev  = 1'b1;
                end
            end
            default: state_d = S_SEARCH;
        endcase
    end

    // clr zeroes the counters first so a same-cycle event still lands on top
    always_comb begin
        prev_d       = ring;
        locked_d     = (state_d == S_LOCKED);
        phase_d      = locked_d ? hot_idx : '0;
        rev_cnt_d    = (clr ? '0 : rev_cnt_q) + REV_W'(rev_ev);
        err_base     = clr ? 8'd0 : err_cnt_q;
        err_cnt_d    = (err_ev && err_base != 8'hFF) ? err_base + 8'd1 : err_base;
        err_sticky_d = (err_sticky_q & ~clr) | err_ev;
        err_pulse_d  = err_ev;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_SEARCH;
            cnt_q        <= '0;
            prev_q       <= '0;
            locked_q     <= 1'b0;
            phase_q      <= '0;
            rev_cnt_q    <= '0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            locked_q     <= locked_d;
            phase_q      <= phase_d;
            rev_cnt_q    <= rev_cnt_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign locked     = locked_q;
    assign phase      = phase_q;
    assign rev_cnt    = rev_cnt_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ring_monitor.sv
// Directed bench for ring_monitor: lock, wrap, errors, holds, clr collisions,
// saturation and asynchronous reset, with hand-computed expectations.
module tb_ring_monitor;

    logic       clk;
    logic       rst;
    logic [3:0] ring;
    logic       step;
    logic       clr;
    logic       locked;
    logic [1:0] phase;
    logic [7:0] rev_cnt;
    logic       err_pulse;
    logic       err_sticky;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    ring_monitor #(.W(4), .REV_W(8), .LOCK_N(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ring       (ring),
        .step       (step),
        .clr        (clr),
        .locked     (locked),
        .phase      (phase),
        .rev_cnt    (rev_cnt),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_locked, input logic [1:0] e_phase,
                             input logic [7:0] e_rev, input logic e_pulse, input logic e_sticky,
                             input logic [7:0] e_errcnt);
        chk({tag, ".locked"},     32'(locked),     32'(e_locked));
        chk({tag, ".phase"},      32'(phase),      32'(e_phase));
        chk({tag, ".rev_cnt"},    32'(rev_cnt),    32'(e_rev));
        chk({tag, ".err_pulse"},  32'(err_pulse),  32'(e_pulse));
        chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(e_sticky));
        chk({tag, ".err_cnt"},    32'(err_cnt),    32'(e_errcnt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] r, input logic s);
        ring = r;
        step = s;
        tick();
    endtask

    initial begin
        rst  = 1'b0;
        ring = 4'b0000;
        step = 1'b1;
        clr  = 1'b0;
        #3;
        check_all("reset", 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b1;

        // basic lock and first revolution
        drive(4'b1000, 1);
        check_all("lock_e1", 0, 0, 0, 0, 0, 0);
        drive(4'b0100, 1);
        check_all("lock_e2", 0, 0, 0, 0, 0, 0);
        drive(4'b0010, 1);
        check_all("lock_e3", 1, 1, 0, 0, 0, 0);
        drive(4'b0001, 1);
        check_all("lock_e4", 1, 0, 0, 0, 0, 0);
        drive(4'b1000, 1);
        check_all("wrap_e5", 1, 3, 1, 0, 0, 0);

        // corrupted sample while locked, then relock
        drive(4'b0110, 1);
        check_all("corrupt", 0, 0, 1, 1, 1, 1);
        drive(4'b0100, 1);
        check_all("relock_e1", 0, 0, 1, 0, 1, 1);
        drive(4'b0010, 1);
        check_all("relock_e2", 0, 0, 1, 0, 1, 1);
        drive(4'b0001, 1);
        check_all("relock_e3", 1, 0, 1, 0, 1, 1);

        // hold cycles keep lock; a change during hold is an error
        drive(4'b0001, 0);
        check_all("hold1", 1, 0, 1, 0, 1, 1);
        drive(4'b0001, 0);
        check_all("hold2", 1, 0, 1, 0, 1, 1);
        drive(4'b0001, 0);
        check_all("hold3", 1, 0, 1, 0, 1, 1);
        drive(4'b1000, 0);
        check_all("hold_move", 0, 0, 1, 1, 1, 2);

        // relock, clr alone, then reversed rotation
        drive(4'b1000, 1);
        drive(4'b0100, 1);
        drive(4'b0010, 1);
        check_all("lock_d", 1, 1, 1, 0, 1, 2);
        clr = 1'b1;
        drive(4'b0001, 1);
        check_all("clr_only", 1, 0, 0, 0, 0, 0);
        clr = 1'b0;
        drive(4'b0010, 1);
        check_all("reverse", 0, 0, 0, 1, 1, 1);

        // 299 more errors: saturation at 255
        for (int i = 0; i < 299; i++) begin
            drive(4'b1000, 1);
            drive(4'b0100, 1);
            drive(4'b0010, 1);
            drive(4'b0100, 1);
            if (i == 98) chk("sat_mid.err_cnt", 32'(err_cnt), 32'd100);
        end
        check_all("saturate", 0, 0, 0, 1, 1, 255);

        // clr colliding with a wrap and with an error
        drive(4'b1000, 1);
        drive(4'b0100, 1);
        drive(4'b0010, 1);
        drive(4'b0001, 1);
        check_all("lock_e", 1, 0, 0, 0, 1, 255);
        clr = 1'b1;
        drive(4'b1000, 1);
        check_all("clr_wrap", 1, 3, 1, 0, 0, 0);
        drive(4'b0110, 1);
        check_all("clr_err", 0, 0, 0, 1, 1, 1);
        clr = 1'b0;

        // asynchronous reset mid-run
        drive(4'b1000, 1);
        drive(4'b0100, 1);
        drive(4'b0010, 1);
        drive(4'b0001, 1);
        drive(4'b1000, 1);
        check_all("pre_rst", 1, 3, 1, 0, 1, 1);
        #2;
        rst = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0, 0);
        drive(4'b0100, 1);
        check_all("in_rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        drive(4'b0100, 1);
        drive(4'b0010, 1);
        check_all("rst_relock_e2", 0, 0, 0, 0, 0, 0);
        drive(4'b0001, 1);
        check_all("rst_relock_e3", 1, 0, 0, 0, 0, 0);

        // bad sample during TRACK falls back silently
        drive(4'b1000, 1);
        drive(4'b0110, 1);
        check_all("err_f", 0, 0, 1, 1, 1, 1);
        drive(4'b0100, 1);
        check_all("track_f", 0, 0, 1, 0, 1, 1);
        drive(4'b1100, 1);
        check_all("track_bad", 0, 0, 1, 0, 1, 1);
        drive(4'b0100, 1);
        drive(4'b0010, 1);
        check_all("final_e2", 0, 0, 1, 0, 1, 1);
        drive(4'b0001, 1);
        check_all("final_e3", 1, 0, 1, 0, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_monitor.md
# ring_monitor

Downstream checker for the one-hot ring counter. Samples the ring's 4-bit state every clock, verifies it is one-hot and rotates in the correct order, and acquires lock after a run of good steps. Once locked, it reports the encoded phase, counts completed revolutions and flags any corruption with pulse, sticky and counted errors. Status logic reads these outputs instead of decoding the raw ring.

## Interface
- W, 4: ring width, ≥2.
- REV_W, 8: revolution counter width.
- LOCK_N, 2: consecutive good advancing steps required to lock, ≥1.
- clk  in  1  clock, rising edge; ring is synchronous to it.
- rst  in  1  reset, asynchronous, active-low.
- ring  in  W  ring counter state.
- step  in  1  1 = ring expected to advance between previous and current sample; tie to 1 for a free-running ring.
- clr  in  1  synchronous clear of rev_cnt, err_cnt, err_sticky.
- locked  out  1  tracker locked.
- phase  out  clog2(W)  index of hot bit while locked, else 0.
- rev_cnt  out  REV_W  completed revolutions, modulo 2^REV_W.
- err_pulse  out  1  one-cycle pulse per error detected while locked.
- err_sticky  out  1  set by any error, cleared only by clr or reset.
- err_cnt  out  8  error count, saturates at 255.

## Operation
- prev register captures ring every edge; reset value 0.
- Rotation order: rot(x) = {x[0], x[W-1:1]}, i.e. 1000→0100→0010→0001→1000 for W=4.
- Per edge, with cur = ring:
  - onehot = exactly one bit of cur set.
  - good_adv = step & onehot & (cur == rot(prev)).
  - good_hold = ~step & onehot & (cur == prev).
  - bad = neither good_adv nor good_hold.
- FSM, 3 states, reset to SEARCH:
  - SEARCH: onehot → TRACK, good count = 0; else stay.
  - TRACK: good_adv → count+1, and count+1 == LOCK_N → LOCKED; good_hold → stay, count unchanged; bad → SEARCH. No error is reported in TRACK.
  - LOCKED: good_adv/good_hold → stay; bad → SEARCH with error event.
- locked = 1 in LOCKED.
- phase = index of cur's hot bit, updated on each edge that ends in LOCKED; 0 otherwise.
- Revolution: an edge that starts in LOCKED with good_adv and cur[W-1] = 1 (wrap from bit 0) increments rev_cnt, which wraps freely.
- Error event: err_pulse = 1 for that cycle, err_sticky ← 1, err_cnt += 1 (saturating at 255).
- clr: rev_cnt, err_cnt and err_sticky restart from 0 in the same edge. A revolution or error in the same cycle still applies, giving rev_cnt = 1, or err_cnt = 1 with err_sticky = 1. clr does not affect the FSM, locked or phase.

## Timing
- All outputs registered. Reset value of every output is 0; prev = 0; FSM = SEARCH.
- Input at edge n is reflected in outputs after edge n (1-cycle latency).
- Lock latency from first valid sample: 1 + LOCK_N advancing edges. With step = 1 and LOCK_N = 2, locked rises after the 3rd edge following reset release.
- An error drops locked after the same edge that sets err_pulse. Relock needs the full SEARCH/TRACK sequence.
- Asynchronous reset mid-operation returns all state and outputs to reset values immediately.
- Hold cycles (step = 0, unchanged ring) neither count toward lock nor break it.

## Test plan
- Reset release, ring 1000, 0100, 0010, 0001, 1000, step = 1 → locked = 1 after edge 3, phase = 1. After edge 5: rev_cnt = 1, phase = 3, no errors.
- Locked, then ring forced 0110 for one cycle → err_pulse = 1 for 1 cycle, err_sticky = 1, err_cnt = 1, locked = 0. Then locked = 1 again 3 edges after a valid one-hot returns.
- Locked, step = 0 for 3 cycles with ring held → locked stays 1, no error, rev_cnt unchanged. Ring changes while step = 0 → error.
- Locked, ring runs reversed (0010 after 0100) → error, err_cnt = 1. Repeat 300 errors → err_cnt = 255.
- clr asserted in the same cycle as a wrap and as an error → rev_cnt = 1, err_cnt = 1, err_sticky = 1, locked unaffected by clr.
- rst pulsed low mid-run → all outputs 0 immediately. After release, lock reacquired on the 3rd edge.
